// File: rtl/exe_issue_scheduler.sv
// In-order issue queue with a destination-register scoreboard. It holds decoded
// vector instructions and releases the head to executeControlUnit once the unit is free and no RAW/WAW hazard exists.
module exe_issue_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_WIDTH-1:0]       in_rs1,
  input  logic [ADDR_WIDTH-1:0]       in_rs2,
  input  logic [ADDR_WIDTH-1:0]       in_rd,
  input  logic                        wb_valid,
  input  logic [ADDR_WIDTH-1:0]       wb_rd,
  output logic                        issue_valid,
  output logic [ADDR_WIDTH-1:0]       issue_rs1,
  output logic [ADDR_WIDTH-1:0]       issue_rs2,
  output logic [ADDR_WIDTH-1:0]       issue_rd,
  output logic [$clog2(DEPTH):0]      count,
  output logic [(2**ADDR_WIDTH)-1:0]  busy_mask
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2**ADDR_WIDTH;

  // The control unit needs instr_valid -> FETCH_A -> FETCH_B before it is idle,
  // so two dead cycles follow every issue decision.
  localparam logic [1:0] COOL_LOAD = 2'd2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
  } instr_t;

  instr_t [DEPTH-1:0] mem_q;
  logic   [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic   [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic   [CW-1:0]    cnt_q, cnt_d;
  logic   [NREG-1:0]  busy_q, busy_d;
  logic   [1:0]       cool_q, cool_d;
  logic               iss_vld_q, iss_vld_d;
  instr_t             iss_q, iss_d;

  instr_t head;
  logic   push, pop, head_hazard;

  assign head        = mem_q[rd_ptr_q];
  assign in_ready    = (cnt_q != CW'(DEPTH));
  assign push        = in_valid && in_ready;
  // Registered scoreboard only: a writeback this cycle does not unblock the head.
  assign head_hazard = busy_q[head.rs1] || busy_q[head.rs2] || busy_q[head.rd];
  assign pop         = (cnt_q != '0) && (cool_q == 2'd0) && !head_hazard;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    cool_d    = cool_q;
    iss_vld_d = 1'b0;
    iss_d     = iss_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (cool_q != 2'd0) cool_d = cool_q - 2'd1;

    // Set after clear so a same-cycle issue to the written-back register wins.
    if (wb_valid) busy_d[wb_rd] = 1'b0;

    if (pop) begin
      busy_d[head.rd] = 1'b1;
      cool_d          = COOL_LOAD;
      iss_vld_d       = 1'b1;
      iss_d           = head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= '0;
      cool_q    <= '0;
      iss_vld_q <= 1'b0;
      iss_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      cool_q    <= cool_d;
      iss_vld_q <= iss_vld_d;
      iss_q     <= iss_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd};
  end

  assign issue_valid = iss_vld_q;
  assign issue_rs1   = iss_q.rs1;
  assign issue_rs2   = iss_q.rs2;
  assign issue_rd    = iss_q.rd;
  assign count       = cnt_q;
  assign busy_mask   = busy_q;

endmodule
